// File: rtl/memory_bus_controller.sv
// Byte-wide external memory bus master: runs one byte or two-byte (little-endian) access per request
// with an acknowledge handshake and a bounded per-phase wait that turns into an error response.
module memory_bus_controller #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      request_valid,
   output logic                      request_ready,
   input  logic                      request_write,
   input  logic                      request_word,
   input  logic [ADDRESS_WIDTH-1:0]  request_address,
   input  logic [2*DATA_WIDTH-1:0]   request_data,
   output logic                      response_valid,
   output logic [2*DATA_WIDTH-1:0]   response_data,
   output logic                      response_error,
   output logic [ADDRESS_WIDTH-1:0]  bus_address,
   output logic [DATA_WIDTH-1:0]     bus_write_data,
   output logic                      bus_read_enable,
   output logic                      bus_write_enable,
   input  logic [DATA_WIDTH-1:0]     bus_read_data,
   input  logic                      bus_acknowledge
);

   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

   state_t                    state_reg,   state_next;
   logic                      write_reg,   write_next;
   logic                      word_reg,    word_next;
   logic [ADDRESS_WIDTH-1:0]  address_reg, address_next;
   logic [2*DATA_WIDTH-1:0]   wdata_reg,   wdata_next;
   logic [2*DATA_WIDTH-1:0]   rdata_reg,   rdata_next;
   logic                      error_reg,   error_next;
   logic [TIMER_WIDTH-1:0]    timer_reg,   timer_next;
   logic                      phase_active;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= IDLE;
         write_reg   <= 1'b0;
         word_reg    <= 1'b0;
         address_reg <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         error_reg   <= 1'b0;
         timer_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         write_reg   <= write_next;
         word_reg    <= word_next;
         address_reg <= address_next;
         wdata_reg   <= wdata_next;
         rdata_reg   <= rdata_next;
         error_reg   <= error_next;
         timer_reg   <= timer_next;
      end
   end

   assign phase_active = (state_reg == LOW) || (state_reg == HIGH);

   always_comb begin
      state_next   = state_reg;
      write_next   = write_reg;
      word_next    = word_reg;
      address_next = address_reg;
      wdata_next   = wdata_reg;
      rdata_next   = rdata_reg;
      error_next   = error_reg;
      timer_next   = timer_reg;
      case (state_reg)
         IDLE: begin
            if (request_valid) begin
               write_next   = request_write;
               word_next    = request_word;
               address_next = request_address;
               wdata_next   = request_data;
               rdata_next   = '0;
               error_next   = 1'b0;
               timer_next   = '0;
               state_next   = LOW;
            end
         end
         LOW, HIGH: begin
            // Acknowledge is tested before the timer so a late ack on the last cycle still succeeds.
            if (bus_acknowledge) begin
               if (!write_reg) begin
                  if (state_reg == LOW) rdata_next[DATA_WIDTH-1:0] = bus_read_data;
                  else                  rdata_next[2*DATA_WIDTH-1:DATA_WIDTH] = bus_read_data;
               end
               timer_next = '0;
               state_next = (state_reg == LOW && word_reg) ? HIGH : RESP;
            end else if (timer_reg == TIMER_LAST) begin
               error_next = 1'b1;
               rdata_next = '0;
               timer_next = '0;
               state_next = RESP;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      request_ready    = (state_reg == IDLE);
      response_valid   = (state_reg == RESP);
      response_error   = (state_reg == RESP) && error_reg;
      response_data    = (state_reg == RESP) ? rdata_reg : '0;
      bus_read_enable  = phase_active && !write_reg;
      bus_write_enable = phase_active && write_reg;
      bus_address      = '0;
      bus_write_data   = '0;
      if (state_reg == LOW) begin
         bus_address    = address_reg;
         bus_write_data = wdata_reg[DATA_WIDTH-1:0];
      end else if (state_reg == HIGH) begin
         bus_address    = address_reg + 1'b1;
         bus_write_data = wdata_reg[2*DATA_WIDTH-1:DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed bench for memory_bus_controller: drives requests and acknowledges from one initial block,
// keeps expected responses in a queue and checks them when response_valid appears.
module tb_memory_bus_controller;

   localparam int T = 15;

   logic        clock = 1'b0;
   logic        reset;
   logic        request_valid, request_ready, request_write, request_word;
   logic [15:0] request_address, request_data;
   logic        response_valid, response_error;
   logic [15:0] response_data, bus_address;
   logic [7:0]  bus_write_data, bus_read_data;
   logic        bus_read_enable, bus_write_enable, bus_acknowledge;

   typedef struct {logic [15:0] data; logic err;} resp_t;
   resp_t sb_q[$];

   int n_asserts = 0;
   int n_fail    = 0;

   memory_bus_controller #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset),
      .request_valid(request_valid), .request_ready(request_ready),
      .request_write(request_write), .request_word(request_word),
      .request_address(request_address), .request_data(request_data),
      .response_valid(response_valid), .response_data(response_data),
      .response_error(response_error), .bus_address(bus_address),
      .bus_write_data(bus_write_data), .bus_read_enable(bus_read_enable),
      .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data),
      .bus_acknowledge(bus_acknowledge)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_response(input string tag);
      resp_t e;
      check({tag, "_valid"}, {15'd0, response_valid}, 16'd1);
      if (sb_q.size() == 0) begin
         n_asserts++;
         n_fail++;
         $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_data"}, response_data, e.data);
         check({tag, "_error"}, {15'd0, response_error}, {15'd0, e.err});
      end
      $display("txn %s: data=%h error=%b", tag, response_data, response_error);
   endtask

   // One full request. A delay >= T means that phase never sees an acknowledge.
   task automatic access(input string tag, input logic wr, input logic wd,
                         input logic [15:0] addr, input logic [15:0] data,
                         input int d0, input int d1, input logic [7:0] b0, input logic [7:0] b1);
      resp_t e;
      int nph;
      int d;
      logic [15:0] a;
      logic [7:0]  rb, wb;
      e.err  = (d0 >= T) || (wd && d0 < T && d1 >= T);
      e.data = (e.err || wr) ? 16'h0000 : (wd ? {b1, b0} : {8'h00, b0});
      nph    = (wd && d0 < T) ? 2 : 1;
      @(negedge clock);
      check({tag, "_ready_idle"}, {15'd0, request_ready}, 16'd1);
      request_valid = 1'b1; request_write = wr; request_word = wd;
      request_address = addr; request_data = data;
      sb_q.push_back(e);
      @(negedge clock);
      request_valid = 1'b0;
      for (int p = 0; p < nph; p++) begin
         d  = (p == 0) ? d0 : d1;
         a  = (p == 0) ? addr : addr + 16'd1;
         rb = (p == 0) ? b0 : b1;
         wb = (p == 0) ? data[7:0] : data[15:8];
         check({tag, "_addr"}, bus_address, a);
         check({tag, "_wdata"}, {8'd0, bus_write_data}, {8'd0, wb});
         check({tag, "_ready_busy"}, {15'd0, request_ready}, 16'd0);
         for (int c = 0; c < T; c++) begin
            check({tag, "_wen"}, {15'd0, bus_write_enable}, {15'd0, wr});
            check({tag, "_ren"}, {15'd0, bus_read_enable}, {15'd0, ~wr});
            if (c == d) begin
               bus_acknowledge = 1'b1; bus_read_data = rb;
               @(negedge clock);
               bus_acknowledge = 1'b0; bus_read_data = 8'h00;
               break;
            end
            @(negedge clock);
         end
      end
      check_response(tag);
      check({tag, "_ready_resp"}, {15'd0, request_ready}, 16'd0);
      check({tag, "_en_resp"}, {14'd0, bus_read_enable, bus_write_enable}, 16'd0);
      @(negedge clock);
      check({tag, "_pulse"}, {15'd0, response_valid}, 16'd0);
      check({tag, "_ready_after"}, {15'd0, request_ready}, 16'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; request_valid = 1'b0; request_write = 1'b0; request_word = 1'b0;
      request_address = 16'h0; request_data = 16'h0; bus_read_data = 8'h0; bus_acknowledge = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_ready", {15'd0, request_ready}, 16'd1);
      check("rst_rvalid", {15'd0, response_valid}, 16'd0);
      check("rst_rdata", response_data, 16'h0000);
      check("rst_addr", bus_address, 16'h0000);
      check("rst_en", {14'd0, bus_read_enable, bus_write_enable}, 16'd0);

      access("byte_read",   1'b0, 1'b0, 16'h1234, 16'h0000, 0, 0, 8'hAB, 8'h00);
      access("word_write",  1'b1, 1'b1, 16'h2000, 16'hBEEF, 1, 1, 8'h00, 8'h00);
      access("word_wrap",   1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, 0, 8'h11, 8'h22);
      access("timeout",     1'b0, 1'b0, 16'h0040, 16'h0000, 99, 0, 8'h55, 8'h00);
      access("last_ack",    1'b0, 1'b0, 16'h0041, 16'h0000, T-1, 0, 8'h66, 8'h00);
      access("word_to_hi",  1'b0, 1'b1, 16'h0050, 16'h0000, 2, 99, 8'h12, 8'h34);
      access("byte_write",  1'b1, 1'b0, 16'h0060, 16'h00C3, 3, 0, 8'h00, 8'h00);

      // Reset while in the HIGH phase abandons the request silently.
      @(negedge clock);
      request_valid = 1'b1; request_write = 1'b0; request_word = 1'b1; request_address = 16'h3000;
      @(negedge clock);
      request_valid = 1'b0; bus_acknowledge = 1'b1; bus_read_data = 8'h77;
      @(negedge clock);
      bus_acknowledge = 1'b0;
      check("rst_hi_addr", bus_address, 16'h3001);
      check("rst_hi_ren", {15'd0, bus_read_enable}, 16'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_hi_en", {14'd0, bus_read_enable, bus_write_enable}, 16'd0);
      check("rst_hi_rvalid", {15'd0, response_valid}, 16'd0);
      check("rst_hi_ready", {15'd0, request_ready}, 16'd1);
      @(negedge clock);
      check("rst_hi_rvalid2", {15'd0, response_valid}, 16'd0);
      $display("txn reset_in_high: aborted");
      access("after_reset", 1'b0, 1'b1, 16'h3000, 16'h0000, 0, 1, 8'h9A, 8'hBC);

      // Back-to-back: valid held high; second request only taken after RESP.
      @(negedge clock);
      request_valid = 1'b1; request_write = 1'b0; request_word = 1'b0; request_address = 16'h0100;
      sb_q.push_back('{16'h005A, 1'b0});
      @(negedge clock);
      check("b2b_ready_low", {15'd0, request_ready}, 16'd0);
      check("b2b_addr1", bus_address, 16'h0100);
      request_address = 16'h0200;
      bus_acknowledge = 1'b1; bus_read_data = 8'h5A;
      @(negedge clock);
      bus_acknowledge = 1'b0;
      check_response("b2b_first");
      check("b2b_ready_resp", {15'd0, request_ready}, 16'd0);
      sb_q.push_back('{16'h00A5, 1'b0});
      @(negedge clock);
      check("b2b_ready_idle", {15'd0, request_ready}, 16'd1);
      check("b2b_idle_en", {15'd0, bus_read_enable}, 16'd0);
      @(negedge clock);
      request_valid = 1'b0;
      check("b2b_addr2", bus_address, 16'h0200);
      check("b2b_ren2", {15'd0, bus_read_enable}, 16'd1);
      bus_acknowledge = 1'b1; bus_read_data = 8'hA5;
      @(negedge clock);
      bus_acknowledge = 1'b0;
      check_response("b2b_second");
      @(negedge clock);

      // Spurious acknowledge while idle must not start anything.
      bus_acknowledge = 1'b1; bus_read_data = 8'hEE;
      @(negedge clock);
      bus_acknowledge = 1'b0;
      check("spur_ready", {15'd0, request_ready}, 16'd1);
      check("spur_rvalid", {15'd0, response_valid}, 16'd0);
      check("spur_en", {14'd0, bus_read_enable, bus_write_enable}, 16'd0);
      @(negedge clock);
      check("spur_rvalid2", {15'd0, response_valid}, 16'd0);
      check("sb_drained", 16'(sb_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
